// File: rtl/spi_ram_pkg.sv
// Shared opcodes and FSM state type for the SPI RAM model.
package spi_ram_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_e;

    function automatic logic op_supported(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for one asynchronous input, with rise/fall pulses in the clk domain.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/spi_ram_model.sv
// Mode-0 SPI slave RAM (READ 0x03 / WRITE 0x02) sampled in the clk domain.
// Optional per-byte access counters are enabled with macro SPI_RAM_ACCESS_CNT_EN.
module spi_ram_model
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic        busy,
    output logic        err_cmd
`ifdef SPI_RAM_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    localparam int MA = $clog2(DEPTH);

    logic cs_sync, cs_fall, cs_rise_unused;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .async_in(spi_cs_n),
        .sync_out(cs_sync), .rise(cs_rise_unused), .fall(cs_fall)
    );
    spi_edge_sync #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .async_in(spi_sclk),
        .sync_out(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_edge_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .async_in(spi_mosi),
        .sync_out(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    logic [7:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0] shift_q, shift_d, shift_nx;
    logic [MA-1:0]     addr_q, addr_d;
    logic              is_rd_q, is_rd_d;
    logic [7:0]        out_sh_q, out_sh_d;
    logic              load_q, load_d;
    logic              wr_pend_q, wr_pend_d;
    logic [7:0]        wr_byte_q, wr_byte_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              armed_q, armed_d;
    logic [1:0]        settle_q, settle_d;
`ifdef SPI_RAM_ACCESS_CNT_EN
    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
`endif

    assign shift_nx = {shift_q[ADDR_W-2:0], mosi_sync};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        is_rd_d   = is_rd_q;
        out_sh_d  = out_sh_q;
        load_d    = load_q;
        wr_pend_d = 1'b0;
        wr_byte_d = wr_byte_q;
        miso_d    = miso_q;
        err_d     = 1'b0;
        armed_d   = armed_q;
        settle_d  = settle_q;
`ifdef SPI_RAM_ACCESS_CNT_EN
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
`endif

        // After reset the synchroniser needs two clocks before cs_n is trustworthy;
        // a command is only accepted once cs_n has really been observed high.
        if (settle_q != 2'd2) settle_d = settle_q + 2'd1;
        if (settle_q == 2'd2 && cs_sync) armed_d = 1'b1;

        if (wr_pend_q) begin
            addr_d = addr_q + MA'(1);
`ifdef SPI_RAM_ACCESS_CNT_EN
            wr_cnt_d = wr_cnt_q + 16'd1;
`endif
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 5'd0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    shift_d   = shift_nx;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        if (op_supported(shift_nx[7:0])) begin
                            state_d = ST_ADDR;
                            is_rd_d = (shift_nx[7:0] == OP_READ);
                        end else begin
                            state_d = ST_IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (sclk_rise) begin
                    shift_d   = shift_nx;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(ADDR_W - 1)) begin
                        bit_cnt_d = 5'd0;
                        addr_d    = shift_nx[MA-1:0];
                        state_d   = is_rd_q ? ST_RDATA : ST_WDATA;
                        load_d    = is_rd_q;
                    end
                end
            end
            ST_RDATA: begin
                // The fetch lands well before the next sclk fall given clk >= 8x sclk.
                if (load_q) begin
                    out_sh_d = mem[addr_q];
                    load_d   = 1'b0;
                end else if (sclk_fall) begin
                    miso_d    = out_sh_q[7];
                    out_sh_d  = {out_sh_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        addr_d    = addr_q + MA'(1);
                        load_d    = 1'b1;
`ifdef SPI_RAM_ACCESS_CNT_EN
                        rd_cnt_d  = rd_cnt_q + 16'd1;
`endif
                    end
                end
            end
            ST_WDATA: begin
                if (sclk_rise) begin
                    shift_d   = shift_nx;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        wr_pend_d = 1'b1;
                        wr_byte_d = shift_nx[7:0];
                    end
                end
            end
            default: ;
        endcase

        if (state_q != ST_IDLE && cs_sync) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 5'd0;
            load_d    = 1'b0;
        end

        oe_d   = (state_d == ST_RDATA);
        miso_d = oe_d ? miso_d : 1'b0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        out_sh_q  <= out_sh_d;
        wr_byte_q <= wr_byte_d;
        is_rd_q   <= is_rd_d;
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 5'd0;
            addr_q    <= '0;
            load_q    <= 1'b0;
            wr_pend_q <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            armed_q   <= 1'b0;
            settle_q  <= 2'd0;
`ifdef SPI_RAM_ACCESS_CNT_EN
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            addr_q    <= addr_d;
            load_q    <= load_d;
            wr_pend_q <= wr_pend_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            armed_q   <= armed_d;
            settle_q  <= settle_d;
`ifdef SPI_RAM_ACCESS_CNT_EN
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
`endif
        end
    end

    // Storage is never reset; a reset cancels any write still pending.
    always_ff @(posedge clk) begin
        if (!rst && wr_pend_q) mem[addr_q] <= wr_byte_q;
    end

    assign spi_miso    = miso_q & oe_q;
    assign spi_miso_oe = oe_q;
    assign busy        = busy_q;
    assign err_cmd     = err_q;
`ifdef SPI_RAM_ACCESS_CNT_EN
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
`endif

endmodule

// File: tb/tb_spi_ram_model.sv
// Self-checking bench for spi_ram_model: directed cases plus random write/read-back against a byte-array model.
module tb_spi_ram_model;

    localparam int DEPTH = 4096;
    localparam int HALF  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_cs_n = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, busy, err_cmd;
`ifdef SPI_RAM_ACCESS_CNT_EN
    logic [15:0] rd_count, wr_count;
`endif

    spi_ram_model #(.ADDR_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .busy(busy), .err_cmd(err_cmd)
`ifdef SPI_RAM_ACCESS_CNT_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] ref_mem [DEPTH];
    logic rd_oe;

    int err_hi = 0;
    int oe_hi = 0;
    int busy_hi = 0;
    always @(posedge clk) begin
        if (err_cmd) err_hi <= err_hi + 1;
        if (spi_miso_oe) oe_hi <= oe_hi + 1;
        if (busy) busy_hi <= busy_hi + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = v[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic [7:0] rx;
        spi_bits(v, 8, rx);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic write_bytes(input int addr, input logic [31:0] data, input int n);
        logic [15:0] a;
        logic [7:0] b;
        a = addr[15:0];
        cs_low();
        send_byte(8'h02);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        for (int i = 0; i < n; i++) begin
            b = data[31-8*i -: 8];
            send_byte(b);
            ref_mem[(int'(a) + i) % DEPTH] = b;
        end
        cs_high();
    endtask

    task automatic read_bytes(input int addr, input int n, output logic [31:0] got);
        logic [15:0] a;
        logic [7:0] rx;
        a = addr[15:0];
        got = 32'h0;
        cs_low();
        send_byte(8'h03);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        for (int i = 0; i < n; i++) begin
            spi_bits(8'h00, 8, rx);
            got[31-8*i -: 8] = rx;
        end
        rd_oe = spi_miso_oe;
        cs_high();
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        logic [7:0] rx;
        int e0, o0, b0, addr, n;
        logic [31:0] data;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_oe", spi_miso_oe, 0);
        check_val("rst_miso", spi_miso, 0);
        check_val("rst_err", err_cmd, 0);
        repeat (4) @(negedge clk);

`ifdef SPI_RAM_ACCESS_CNT_EN
        check_val("cnt_rd_init", rd_count, 0);
        check_val("cnt_wr_init", wr_count, 0);
        write_bytes(16'h0040, 32'h0102_0300, 3);
        read_bytes(16'h0040, 2, got);
        check_val("cnt_wr", wr_count, 3);
        check_val("cnt_rd", rd_count, 2);
        pulse_rst();
        repeat (4) @(negedge clk);
        check_val("cnt_wr_rst", wr_count, 0);
        check_val("cnt_rd_rst", rd_count, 0);
`endif

        // Basic write then read back.
        write_bytes(16'h0010, 32'hA53C_0000, 2);
        read_bytes(16'h0010, 2, got);
        check_val("rd_a5", got[31:24], 8'hA5);
        check_val("rd_3c", got[23:16], 8'h3C);
        check_val("rd_oe", rd_oe, 1);
        check_val("idle_oe", spi_miso_oe, 0);

        // Address wrap at the top of memory.
        write_bytes(16'h0FFF, 32'h1122_0000, 2);
        read_bytes(16'h0FFF, 2, got);
        check_val("wrap_11", got[31:24], 8'h11);
        check_val("wrap_22", got[23:16], 8'h22);
        read_bytes(16'h0000, 1, got);
        check_val("wrap_mem0", got[31:24], 8'h22);

        // Unsupported opcode.
        e0 = err_hi;
        o0 = oe_hi;
        cs_low();
        send_byte(8'h9F);
        repeat (4) @(negedge clk);
        check_val("bad_op_busy", busy, 1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h55);
        check_val("bad_op_busy_hold", busy, 1);
        cs_high();
        check_val("bad_op_idle", busy, 0);
        check_val("bad_op_err_len", err_hi - e0, 1);
        check_val("bad_op_oe", oe_hi - o0, 0);
        read_bytes(16'h0010, 1, got);
        check_val("bad_op_mem", got[31:24], 8'hA5);

        // Partial byte is discarded.
        write_bytes(16'h0020, 32'h5A00_0000, 1);
        cs_low();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        spi_bits(8'hFF, 5, rx);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("partial_busy", busy, 0);
        repeat (6) @(negedge clk);
        read_bytes(16'h0020, 1, got);
        check_val("partial_mem", got[31:24], 8'h5A);

        // Reset in the middle of a read; later edges with cs_n still low are ignored.
        cs_low();
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h10);
        spi_bits(8'h00, 3, rx);
        pulse_rst();
        check_val("rrst_oe", spi_miso_oe, 0);
        check_val("rrst_busy", busy, 0);
        o0 = oe_hi;
        b0 = busy_hi;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'hEE);
        check_val("rrst_oe_quiet", oe_hi - o0, 0);
        check_val("rrst_busy_quiet", busy_hi - b0, 0);
        cs_high();
        read_bytes(16'h0010, 1, got);
        check_val("rrst_after", got[31:24], 8'hA5);

        // Reset in the middle of a write leaves memory untouched.
        write_bytes(16'h0030, 32'h7700_0000, 1);
        cs_low();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h30);
        spi_bits(8'h88, 4, rx);
        pulse_rst();
        send_byte(8'hCC);
        send_byte(8'hCC);
        cs_high();
        read_bytes(16'h0030, 1, got);
        check_val("wrst_mem", got[31:24], 8'h77);

        // Random bursts, including addresses above DEPTH that must fold modulo DEPTH.
        for (int t = 0; t < 8; t++) begin
            addr = int'($urandom_range(0, 65535));
            n    = int'($urandom_range(1, 4));
            data = $urandom;
            write_bytes(addr, data, n);
            read_bytes(addr, n, got);
            for (int i = 0; i < n; i++) begin
                check_val($sformatf("rand%0d_b%0d", t, i), got[31-8*i -: 8],
                          ref_mem[(addr + i) % DEPTH]);
            end
        end

        // Read a random byte back through an aliased address.
        addr = int'($urandom_range(0, DEPTH - 1));
        data = $urandom;
        write_bytes(addr, data, 1);
        read_bytes(addr + DEPTH * int'($urandom_range(1, 15)), 1, got);
        check_val("alias", got[31:24], ref_mem[addr]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_model.md
SPI_RAM_MODEL -- requirements
Module: spi_ram_model

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the number of address bits received per command (16 or 24).
REQ-002 SHALL have parameter DEPTH, default 4096, meaning storage bytes; a power of two, at most 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port spi_cs_n, input, 1 bit: chip select, active low, asynchronous to clk.
REQ-006 SHALL have port spi_sclk, input, 1 bit: SPI mode-0 serial clock, asynchronous to clk.
REQ-007 SHALL have port spi_mosi, input, 1 bit: serial data in, MSB first.
REQ-008 SHALL have port spi_miso, output, 1 bit: serial data out, MSB first.
REQ-009 SHALL have port spi_miso_oe, output, 1 bit: high only while the RDATA state is driving data.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port err_cmd, output, 1 bit: one-clk pulse on an unsupported opcode.

Function
REQ-012 SHALL pass spi_cs_n, spi_sclk and spi_mosi through 2-flop synchronisers; sclk rise and fall are edge-detected in the clk domain; clk frequency SHALL be at least 8x the sclk frequency.
REQ-013 SHALL sample mosi on each detected sclk rise, and SHALL update miso on each detected sclk fall.
REQ-014 SHALL implement the states IDLE, CMD, ADDR, RDATA, WDATA and IGNORE; a synchronised cs_n fall SHALL move IDLE to CMD with the bit counter cleared.
REQ-015 SHALL, on the 8th bit in CMD, go to ADDR for opcode 0x03 (READ) or 0x02 (WRITE); any other opcode SHALL go to IGNORE and pulse err_cmd for one clk.
REQ-016 SHALL, after ADDR_W address bits, reduce the address modulo DEPTH; READ then goes to RDATA and WRITE goes to WDATA.
REQ-017 In RDATA, SHALL load mem[addr] into the out-shifter before the next sclk fall and drive its MSB on that fall; after each 8th bit the address increments, wrapping DEPTH-1 -> 0, and the next byte follows with no gap.
REQ-018 In WDATA, SHALL write each complete 8-bit byte to mem[addr] in the clk cycle after its 8th sclk rise, then increment the address with wrap.
REQ-019 A partial byte at cs_n rise SHALL be discarded, with no write, in every state.
REQ-020 A synchronised cs_n rise in any state SHALL return the FSM to IDLE within 1 clk and deassert spi_miso_oe; edges and mosi SHALL be ignored while cs_n is high.
REQ-021 SHALL drive spi_miso to 0 whenever spi_miso_oe is low.
REQ-022 Memory contents SHALL be retained across cs_n cycles and SHALL be undefined after power-up.

Reset
REQ-023 rst SHALL set state=IDLE, bit counter=0, address=0, spi_miso=0, spi_miso_oe=0, busy=0, err_cmd=0 and synchroniser flops to idle levels (cs_n=1, sclk=0); memory is not cleared.
REQ-024 rst during a transaction SHALL abort it with no further memory write; after rst, a new command SHALL be accepted only after cs_n has been seen high and then low.

Configuration
REQ-025 With macro SPI_RAM_ACCESS_CNT_EN defined, SHALL add outputs rd_count[15:0] and wr_count[15:0], incremented (wrapping at 16 bits) once per byte read or written and cleared by rst.
REQ-026 Without SPI_RAM_ACCESS_CNT_EN, those ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-027 Package spi_ram_pkg SHALL hold the opcode constants (OP_READ=0x03, OP_WRITE=0x02) and the state enumeration type.
REQ-028 Synchronisation and edge detection SHALL live in sub-module spi_edge_sync, instantiated once per input, with rise and fall pulse outputs.

Verification
REQ-029 WRITE 0x02, addr 0x0010, data A5 3C, cs_n high; then READ 0x03 from 0x0010 -> miso returns A5 then 3C.
REQ-030 With DEPTH=4096: WRITE at 0x0FFF with bytes 11 22 -> mem[0xFFF]=11, mem[0x000]=22; READ from 0x0FFF returns 11 22.
REQ-031 Opcode 0x9F -> err_cmd high for exactly 1 clk, miso_oe stays 0, no memory change, busy until cs_n rises.
REQ-032 WRITE 0x0020 with 5 data bits, then cs_n rises -> mem[0x0020] unchanged; busy=0 within 3 clk of the cs_n rise.
REQ-033 rst pulsed during RDATA -> miso_oe=0 and state IDLE the next clk; sclk edges while cs_n is still low are ignored.
REQ-034 With SPI_RAM_ACCESS_CNT_EN: write 3 bytes, then read 2 -> wr_count=3, rd_count=2; rst -> both 0.
